// File: rtl/if_stage_pkg.sv
// Shared MIPS fetch definitions: pc_src codes, NOP/reset defaults, IF/ID register layout.
package if_stage_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_JR     = 2'b11
  } pc_src_e;

  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // Word-scaled, sign-extended branch displacement.
  function automatic logic [31:0] branch_off(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC mux: sequential, branch, jump and register targets, mod 2^32.
// Zero latency; no flow control.
module npc_calc
  import if_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] id_pc_plus4,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_jidx,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc,
  output logic        redirect
);

  assign pc_plus4 = pc + 32'd4;
  assign redirect = (pc_src_e'(pc_src) != PCSRC_SEQ);

  always_comb begin
    npc = pc_plus4;
    unique case (pc_src_e'(pc_src))
      PCSRC_SEQ:    npc = pc_plus4;
      PCSRC_BRANCH: npc = id_pc_plus4 + branch_off(id_imm16);
      PCSRC_JUMP:   npc = {id_pc_plus4[31:28], id_jidx, 2'b00};
      // Misaligned register targets are silently truncated to a word boundary.
      PCSRC_JR:     npc = jr_target & 32'hFFFF_FFFC;
      default:      npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register driving imem, IF/ID register one cycle behind.
// Stall holds PC and IF/ID; redirect or flush bubbles IF/ID; redirect overrides stall.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [31:0] id_pc_plus4,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_jidx,
  input  logic [31:0] jr_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic        redirect;
  ifid_t       ifid;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

  npc_calc u_npc_calc (
    .pc          (pc),
    .pc_src      (pc_src),
    .id_pc_plus4 (id_pc_plus4),
    .id_imm16    (id_imm16),
    .id_jidx     (id_jidx),
    .jr_target   (jr_target),
    .pc_plus4    (pc_plus4),
    .npc         (npc),
    .redirect    (redirect)
  );

  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else if (redirect || !stall)
      pc <= npc;
  end

  // The word fetched alongside a redirect is the squashed sequential slot.
  always_ff @(posedge clk) begin
    if (reset)
      ifid <= BUBBLE;
    else if (redirect || flush)
      ifid <= BUBBLE;
    else if (!stall)
      ifid <= '{instr: imem_instr, pc_plus4: pc_plus4, valid: 1'b1};
  end

  assign imem_addr     = pc;
  assign ifid_instr    = ifid.instr;
  assign ifid_pc_plus4 = ifid.pc_plus4;
  assign ifid_valid    = ifid.valid;

endmodule
